// File: rtl/imm_gen_pipe_pkg.sv
// Shared immediate-select encodings. The decoder, the hazard logic and
// the immediate generator import this package.
package imm_defs;

    localparam int IMM_SEL_W = 3;

    localparam logic [IMM_SEL_W-1:0] IMM_TYPE_I = 3'b001;
    localparam logic [IMM_SEL_W-1:0] IMM_TYPE_B = 3'b010;
    localparam logic [IMM_SEL_W-1:0] IMM_TYPE_J = 3'b011;
    localparam logic [IMM_SEL_W-1:0] IMM_TYPE_S = 3'b100;
    localparam logic [IMM_SEL_W-1:0] IMM_TYPE_U = 3'b101;
    localparam logic [IMM_SEL_W-1:0] IMM_TYPE_Z = 3'b110;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bus of the immediate generator: decoder-side push channel and
// ID/EX-side pop channel. The block itself uses the slave modport.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    import imm_defs::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [IMM_SEL_W-1:0] in_imm_sel;
    logic [XLEN-1:0]      in_pc;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_imm;
    logic [XLEN-1:0]      out_target;
    logic [IMM_SEL_W-1:0] out_sel;
    logic                 out_illegal;

    modport slave (
        input  in_valid, in_inst, in_imm_sel, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_sel, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_imm_sel, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_sel, out_illegal
    );

endinterface

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational immediate extraction from a raw instruction
// word. Every format is first assembled as a 32-bit value and then
// sign-extended to XLEN, so U-type sign-extends from bit 31 on XLEN=64
// and the zero-extended CSR uimm stays positive.
// Build option: IMM_ZICSR_EN enables select 3'b110 (CSR uimm); without it
// that select is reported illegal.
module imm_extract
    import imm_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          inst,
    input  logic [IMM_SEL_W-1:0] sel,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    logic [31:0] imm32;
    logic        unused_opcode;

    // Opcode bits never contribute to any immediate.
    assign unused_opcode = ^inst[6:0];

    // Per-format field assembly; unsupported selects give zero and flag illegal.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (sel)
            IMM_TYPE_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_TYPE_B: imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_TYPE_J: imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_TYPE_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_TYPE_U: imm32 = {inst[31:12], 12'b0};
`ifdef IMM_ZICSR_EN
            IMM_TYPE_Z: imm32 = {27'b0, inst[19:15]};
`endif
            default:    illegal = 1'b1;
        endcase
    end

    // Widen to the datapath; a no-op for XLEN=32.
    always_comb begin
        imm = XLEN'(signed'(imm32));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator between the decoder and the
// ID/EX register. Immediate, pc+imm target, select and illegal flag are
// computed at enqueue and held in a 2-entry in-order skid FIFO.
// in_ready depends only on the occupancy count, so there is no
// combinational path from out_ready back to the decoder.
// Flush (from the hazard unit) empties the FIFO and drops any same-cycle push.
// Build option: IMM_ZICSR_EN (see imm_extract) enables the CSR uimm select.
module imm_gen_pipe
    import imm_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    imm_gen_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      target;
        logic [IMM_SEL_W-1:0] sel;
        logic                 illegal;
    } entry_t;

    entry_t          mem_q [2];
    entry_t          wr_entry;
    entry_t          head;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            push, pop;
    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst    (bus.in_inst),
        .sel     (bus.in_imm_sel),
        .imm     (ext_imm),
        .illegal (ext_illegal)
    );

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);

    // Flush suppresses both sides of the handshake for this cycle.
    assign push = bus.in_valid  & bus.in_ready  & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    // Entry written at enqueue; target wraps modulo 2^XLEN.
    always_comb begin
        wr_entry         = '0;
        wr_entry.imm     = ext_imm;
        wr_entry.target  = bus.in_pc + ext_imm;
        wr_entry.sel     = bus.in_imm_sel;
        wr_entry.illegal = ext_illegal;
    end

    // Pointer and occupancy next-state; 1-bit pointers wrap freely.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Head entry, forced to zero when the FIFO is empty.
    always_comb begin
        head = '0;
        if (bus.out_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign bus.out_imm     = head.imm;
    assign bus.out_target  = head.target;
    assign bus.out_sel     = head.sel;
    assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance driven with the
// same stimulus and checked against a queue-based reference model.
module tb_imm_gen_pipe;
    import imm_defs::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt64;
        logic [31:0] tgt32;
        logic [2:0]  sel;
        logic        ill;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int bits);
        if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Immediate rules evaluated arithmetically on the instruction word.
    function automatic void ref_imm(input logic [31:0] inst, input logic [2:0] sel,
                                    output logic [63:0] imm, output logic ill);
        longint i;
        i   = longint'({32'b0, inst});
        ill = 1'b0;
        imm = '0;
        case (sel)
            3'd1: imm = sx(i >> 20, 12);
            3'd2: imm = sx((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                           (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1), 13);
            3'd3: imm = sx((((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) |
                           (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1), 21);
            3'd4: imm = sx(((i >> 25) << 5) | ((i >> 7) & 31), 12);
            3'd5: imm = sx(i & 64'hFFFF_F000, 32);
`ifdef IMM_ZICSR_EN
            3'd6: imm = (i >> 15) & 31;
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance model.
    task automatic step(input logic v, input logic [31:0] inst, input logic [2:0] sel,
                        input logic [63:0] pc, input logic ordy, input logic fl, input logic r);
        exp_t h;
        exp_t e;
        logic do_push;
        logic do_pop;
        h = '{default: '0};
        if (q.size() != 0) h = q[0];
        chk("in_ready32",  b32.in_ready,    q.size() != 2);
        chk("out_valid32", b32.out_valid,   q.size() != 0);
        chk("imm32",       b32.out_imm,     h.imm[31:0]);
        chk("target32",    b32.out_target,  h.tgt32);
        chk("sel32",       b32.out_sel,     h.sel);
        chk("illegal32",   b32.out_illegal, h.ill);
        chk("in_ready64",  b64.in_ready,    q.size() != 2);
        chk("out_valid64", b64.out_valid,   q.size() != 0);
        chk("imm64",       b64.out_imm,     h.imm);
        chk("target64",    b64.out_target,  h.tgt64);
        chk("sel64",       b64.out_sel,     h.sel);
        chk("illegal64",   b64.out_illegal, h.ill);

        b32.in_valid = v;     b64.in_valid = v;
        b32.in_inst = inst;   b64.in_inst = inst;
        b32.in_imm_sel = sel; b64.in_imm_sel = sel;
        b32.in_pc = pc[31:0]; b64.in_pc = pc;
        b32.out_ready = ordy; b64.out_ready = ordy;
        flush = fl;
        rst = r;

        if (r || fl) begin
            q.delete();
        end else begin
            do_push = v && (q.size() != 2);
            do_pop  = ordy && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                ref_imm(inst, sel, e.imm, e.ill);
                e.tgt64 = pc + e.imm;
                e.tgt32 = pc[31:0] + e.imm[31:0];
                e.sel   = sel;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        tv[0] = '{32'hFFF00093, IMM_TYPE_I, 32'h100,  32'hFFFFFFFF, 32'h000000FF, 1'b0};
        tv[1] = '{32'hFE000EE3, IMM_TYPE_B, 32'h200,  32'hFFFFFFFC, 32'h000001FC, 1'b0};
        tv[2] = '{32'h0080006F, IMM_TYPE_J, 32'h300,  32'h00000008, 32'h00000308, 1'b0};
        tv[3] = '{32'h00112623, IMM_TYPE_S, 32'h40,   32'h0000000C, 32'h0000004C, 1'b0};
        tv[4] = '{32'h123450B7, IMM_TYPE_U, 32'h1000, 32'h12345000, 32'h12346000, 1'b0};
        tv[5] = '{32'h12345678, 3'b111,     32'h10,   32'h00000000, 32'h00000010, 1'b1};
        tv[6] = '{32'h12345678, 3'b000,     32'h14,   32'h00000000, 32'h00000014, 1'b1};
`ifdef IMM_ZICSR_EN
        tv[7] = '{32'h000FD073, IMM_TYPE_Z, 32'h20,   32'h0000001F, 32'h0000003F, 1'b0};
`else
        tv[7] = '{32'h000FD073, IMM_TYPE_Z, 32'h20,   32'h00000000, 32'h00000020, 1'b1};
`endif
        tv[8] = '{32'h80000093, IMM_TYPE_I, 32'h10,   32'hFFFFF800, 32'hFFFFF810, 1'b0};

        rst = 1'b1; flush = 1'b0;
        b32.in_valid = 1'b0; b64.in_valid = 1'b0;
        b32.in_inst = '0;    b64.in_inst = '0;
        b32.in_imm_sel = '0; b64.in_imm_sel = '0;
        b32.in_pc = '0;      b64.in_pc = '0;
        b32.out_ready = 1'b0; b64.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Table vectors back-to-back with out_ready high: one per cycle.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tv[i].inst, tv[i].sel, {32'b0, tv[i].pc}, 1'b1, 1'b0, 1'b0);
            chk("tv_valid",   b32.out_valid,   1'b1);
            chk("tv_imm",     b32.out_imm,     tv[i].imm);
            chk("tv_target",  b32.out_target,  tv[i].tgt);
            chk("tv_illegal", b32.out_illegal, tv[i].ill);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: three U pushes with out_ready low.
        step(1'b1, 32'h123450B7, IMM_TYPE_U, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h234560B7, IMM_TYPE_U, 64'h4, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", b32.in_ready, 1'b0);
        chk("bp_head",     b32.out_imm,  32'h12345000);
        step(1'b1, 32'h345670B7, IMM_TYPE_U, 64'h8, 1'b0, 1'b0, 1'b0);
        chk("bp_head_hold", b32.out_imm, 32'h12345000);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_drain2", b32.out_imm, 32'h23456000);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_empty", b32.out_valid, 1'b0);

        // Flush with a full FIFO and a same-cycle push.
        step(1'b1, 32'hFFF00093, IMM_TYPE_I, 64'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0080006F, IMM_TYPE_J, 64'h300, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, IMM_TYPE_U, 64'h500, 1'b0, 1'b1, 1'b0);
        chk("fl_valid", b32.out_valid, 1'b0);
        chk("fl_ready", b32.in_ready,  1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("fl_dropped", b64.out_valid, 1'b0);

        // 64-bit U sign extension, then reset mid-stream.
        step(1'b1, 32'h800000B7, IMM_TYPE_U, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("u64_imm", b64.out_imm, 64'hFFFFFFFF80000000);
        chk("u32_imm", b32.out_imm, 32'h80000000);
        step(1'b1, 32'hFFF00093, IMM_TYPE_I, 64'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0080006F, IMM_TYPE_J, 64'h300, 1'b0, 1'b0, 1'b1);
        chk("rst_valid",   b64.out_valid,   1'b0);
        chk("rst_imm",     b64.out_imm,     64'h0);
        chk("rst_target",  b64.out_target,  64'h0);
        chk("rst_sel",     b64.out_sel,     3'b0);
        chk("rst_illegal", b64.out_illegal, 1'b0);
        chk("rst_ready",   b64.in_ready,    1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the ID-stage immediate generator. It accepts one instruction word, immediate-type select and PC per handshake. It buffers them in a 2-entry skid FIFO and emits the sign-extended XLEN-bit immediate, the precomputed `pc + imm` target and an illegal-select flag. It sits between the decoder and the ID/EX register, with `flush` driven by the hazard unit.

## Interface
- `XLEN`, 32: datapath width; legal values 32 and 64.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered entries and any same-cycle input.
- `in_valid`  in  1  upstream has a valid entry.
- `in_ready`  out  1  block can accept an entry this cycle.
- `in_inst`  in  32  raw instruction word.
- `in_imm_sel`  in  3  immediate type select.
- `in_pc`  in  XLEN  PC of `in_inst`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts head entry.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_target`  out  XLEN  `pc + imm`, modulo 2^XLEN.
- `out_sel`  out  3  select of head entry, passed through.
- `out_illegal`  out  1  head entry used an unsupported select.

## Operation
- Select encodings:
  - I = 3'b001: `{sext inst[31], inst[31:20]}`.
  - B = 3'b010: `{sext, inst[7], inst[30:25], inst[11:8], 0}`.
  - J = 3'b011: `{sext, inst[19:12], inst[20], inst[30:21], 0}`.
  - S = 3'b100: `{sext, inst[31:25], inst[11:7]}`.
  - U = 3'b101: `{inst[31:12], 12'b0}`, sign-extended from bit 31 when XLEN=64.
  - Z = 3'b110: zero-extended `inst[19:15]`; only when configured (see Configuration).
- Any other select, or Z when not configured: `imm = 0`, `illegal = 1`.
- Immediate and target are computed at enqueue and stored per entry. Stored fields are imm, target, sel and illegal; the raw inst is not stored.
- FIFO behaviour:
  - 2 entries, strict in-order delivery.
  - Count register ranges 0..2.
  - Push when `in_valid & in_ready`; pop when `out_valid & out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
- `in_ready = (count != 2)`. It depends only on state and has no combinational path from `out_ready`.
- `out_valid = (count != 0)`. Outputs always reflect the head entry.
- Head outputs hold stable while `out_valid & ~out_ready`.
- Priority: `rst` > `flush` > push/pop.
  - On flush, count becomes 0 at the next edge.
  - The same-cycle push is dropped, even though `in_ready` was 1.
- Output data are don't-care-free: when `out_valid = 0`, `out_imm`, `out_target` and `out_sel` read 0 and `out_illegal` reads 0.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on `out_*` with `out_valid = 1` after edge N.
- Throughput is 1 entry per cycle with `out_ready` held high, at steady-state count 1.
- Stall absorption: `out_ready` low for k cycles while `in_valid` stays high fills the FIFO to 2. `in_ready` drops the cycle after the second push.
- Reset values: `out_valid = 0`, `in_ready = 1`, `out_imm = 0`, `out_target = 0`, `out_sel = 0`, `out_illegal = 0`, count = 0.
- Reset mid-operation clears all entries with no output. Flush behaves identically.
- Pointer wrap-around: 1-bit read/write pointers toggle and wrap freely; the count is authoritative for full/empty.

## Configuration
- `IMM_ZICSR_EN` defined: select 3'b110 produces the zero-extended 5-bit CSR uimm with `illegal = 0`, and the target is still `pc + imm`.
- `IMM_ZICSR_EN` undefined: 3'b110 is treated as illegal (`imm = 0`, `illegal = 1`).

## Structure
- Shared package `imm_defs`: select encodings `IMM_TYPE_I/B/J/S/U/Z` and an `IMM_SEL_W = 3` constant. The decoder and hazard logic reuse them.
- One sub-module `imm_extract`:
  - Combinational, parametrised by XLEN.
  - Inputs: inst, sel. Outputs: imm, illegal.
  - Instantiated once at the FIFO write side.
- Top level contains the adder, FIFO storage, pointers, count and handshake.

## Test plan
- I type: inst 0xFFF00093, sel 001, pc 0x100 → next cycle `out_imm = 0xFFFFFFFF`, `out_target = 0x000000FF`, `illegal = 0`.
- B and J back-to-back with `out_ready = 1`:
  - B: 0xFE000EE3 at pc 0x200 → `imm 0xFFFFFFFC`, `target 0x1FC`.
  - J: 0x0080006F at pc 0x300 → `imm 0x8`, `target 0x308`.
  - Both appear on consecutive cycles.
- Backpressure: `out_ready = 0`, push 3 U entries (0x123450B7 …) → `in_ready = 0` after the 2nd push; the head holds `0x12345000` stable. Raising `out_ready` drains the entries in order.
- Flush with count = 2 plus a same-cycle push → next cycle `out_valid = 0`, `in_ready = 1`, and the pushed entry never appears.
- Select 3'b110 with inst 0x000FD073:
  - With `IMM_ZICSR_EN`: `imm = 0x1F`, `illegal = 0`.
  - Without it: `imm = 0`, `illegal = 1`.
  - Select 3'b111 is illegal in both builds.
- XLEN = 64, U type with inst 0x800000B7 → `imm = 0xFFFFFFFF80000000`. Mid-stream `rst` → all outputs 0 the next cycle.
